// File: rtl/tri_fetch_seq_if.sv
// Bundles the read-engine burst port and the triangle output stream of tri_fetch_seq.
// master = sequencer side, slave = read engine plus triangle consumer.
interface tri_fetch_seq_if #(
  parameter int WORDS_PER_TRI = 9,
  parameter int MAX_NREAD     = 64,
  parameter int IDX_W         = 16
);
  logic [31:0]                 sdr_baseaddr;
  logic [29:0]                 sdr_nelems;
  logic                        sdr_readstart;
  logic                        sdr_readend;
  logic [32*MAX_NREAD-1:0]     sdr_readdata;
  logic                        tri_valid;
  logic                        tri_ready;
  logic [32*WORDS_PER_TRI-1:0] tri_data;
  logic [IDX_W-1:0]            tri_index;
  logic                        tri_last;

  modport master (
    output sdr_baseaddr, sdr_nelems, sdr_readstart,
    input  sdr_readend, sdr_readdata,
    output tri_valid, tri_data, tri_index, tri_last,
    input  tri_ready
  );

  modport slave (
    input  sdr_baseaddr, sdr_nelems, sdr_readstart,
    output sdr_readend, sdr_readdata,
    input  tri_valid, tri_data, tri_index, tri_last,
    output tri_ready
  );
endinterface

// File: rtl/tri_fetch_seq.sv
// Walks a packed triangle array in SDRAM, one read burst per triangle, and streams
// whole triangles out; a capture buffer lets the next fetch overlap a stalled consumer.
module tri_fetch_seq #(
  parameter int WORDS_PER_TRI = 9,
  parameter int MAX_NREAD     = 64,
  parameter int IDX_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [IDX_W-1:0] num_tris,
  output logic             busy,
  output logic             done,
  tri_fetch_seq_if.master  bus
);

  localparam int          DATA_W    = 32 * WORDS_PER_TRI;
  localparam logic [31:0] ADDR_STEP = 32'(4 * WORDS_PER_TRI);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t            state_r;
  logic [31:0]       cur_addr_r;
  logic [IDX_W-1:0]  num_tris_r;
  logic [IDX_W-1:0]  fetch_cnt_r;
  logic [DATA_W-1:0] capture_r;

  logic              accept_s;
  logic              slot_free_s;
  logic              last_s;
  logic              load_s;
  logic [DATA_W-1:0] capture_next_s;
  logic [DATA_W-1:0] load_data_s;

  // Slices arrive with all other bits zero, so OR-accumulation rebuilds the record.
  assign capture_next_s = capture_r | bus.sdr_readdata[DATA_W-1:0];
  assign accept_s       = bus.tri_valid & bus.tri_ready;
  assign slot_free_s    = ~bus.tri_valid | bus.tri_ready;
  assign last_s         = (fetch_cnt_r == (num_tris_r - IDX_ONE));
  assign load_s         = ((state_r == WAIT) & bus.sdr_readend & slot_free_s) |
                          ((state_r == HOLD) & accept_s);
  assign load_data_s    = (state_r == HOLD) ? capture_r : capture_next_s;
  assign bus.sdr_nelems = 30'(WORDS_PER_TRI);

  // Sequencer FSM with registered burst requests and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      cur_addr_r        <= 32'd0;
      num_tris_r        <= '0;
      fetch_cnt_r       <= '0;
      capture_r         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.sdr_baseaddr  <= 32'd0;
      bus.sdr_readstart <= 1'b0;
      bus.tri_valid     <= 1'b0;
      bus.tri_data      <= '0;
      bus.tri_index     <= '0;
      bus.tri_last      <= 1'b0;
    end else begin
      done              <= 1'b0;
      bus.sdr_readstart <= 1'b0;
      if (accept_s) begin
        bus.tri_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            cur_addr_r  <= base_addr;
            num_tris_r  <= num_tris;
            fetch_cnt_r <= '0;
            if (num_tris == '0) begin
              done <= 1'b1;
            end else begin
              busy              <= 1'b1;
              bus.sdr_baseaddr  <= base_addr;
              bus.sdr_readstart <= 1'b1;
              state_r           <= ISSUE;
            end
          end
        end
        ISSUE: begin
          capture_r <= '0;
          state_r   <= WAIT;
        end
        WAIT: begin
          capture_r <= capture_next_s;
          if (bus.sdr_readend && !slot_free_s) begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          state_r <= HOLD;
        end
        GAP: begin
          bus.sdr_baseaddr  <= cur_addr_r;
          bus.sdr_readstart <= 1'b1;
          state_r           <= ISSUE;
        end
        DRAIN: begin
          if (accept_s) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // A load refills the slot in the same cycle it is vacated, so valid stays high.
      if (load_s) begin
        bus.tri_data  <= load_data_s;
        bus.tri_valid <= 1'b1;
        bus.tri_index <= fetch_cnt_r;
        bus.tri_last  <= last_s;
        fetch_cnt_r   <= fetch_cnt_r + IDX_ONE;
        cur_addr_r    <= cur_addr_r + ADDR_STEP;
        state_r       <= last_s ? DRAIN : GAP;
      end
    end
  end

endmodule

// File: tb/tb_tri_fetch_seq.sv
// Scoreboard bench for tri_fetch_seq: a read-engine model returns 16-bit slices and
// pushes the expected triangle per burst; a monitor pops and compares on acceptance.
module tb_tri_fetch_seq;
  localparam int W   = 9;
  localparam int DW  = 32 * W;
  localparam int IXW = 16;

  typedef struct {
    logic [DW-1:0]  data;
    logic [IXW-1:0] idx;
    logic           last;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [31:0]     base_addr;
  logic [IXW-1:0]  num_tris;
  logic            busy, done;

  tri_fetch_seq_if #(.WORDS_PER_TRI(W), .MAX_NREAD(64), .IDX_W(IXW)) bus ();

  tri_fetch_seq #(.WORDS_PER_TRI(W), .MAX_NREAD(64), .IDX_W(IXW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_tris(num_tris), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t sb[$];
  int acc_cyc[$];

  logic [31:0] run_base;
  int run_num, start_cyc;
  int rs_cnt, re_cnt, done_cnt, acc_cnt;
  int last_end_cyc = -100;
  int last_acc_cyc = -100;
  logic outstanding = 1'b0;
  logic prev_stall = 1'b0, prev_valid = 1'b0;
  logic [DW-1:0] prev_data, last_acc_data;
  logic [IXW-1:0] prev_idx, last_acc_idx;
  logic prev_last, last_acc_last;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_val(input logic [31:0] addr, input int i);
    if (addr == 32'h0000_1000) return 32'h11 + 32'(i);
    else return {addr[15:0] ^ 16'hA5C3 ^ 16'(i), addr[15:0] + 16'h0100 + 16'(i)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Read-engine model: pushes the expected triangle, then returns one 16-bit slice per cycle.
  initial begin
    logic [31:0] addr, wv;
    exp_t e;
    logic aborted;
    int slot;
    bus.sdr_readend  = 1'b0;
    bus.sdr_readdata = '0;
    forever begin
      @(negedge clk);
      if (bus.sdr_readstart && !reset) begin
        addr   = bus.sdr_baseaddr;
        e.data = '0;
        for (int w = 0; w < W; w++) e.data[32*w +: 32] = word_val(addr, w);
        slot   = int'((addr - run_base) / 32'd36);
        e.idx  = IXW'(slot);
        e.last = (slot == run_num - 1);
        sb.push_back(e);
        aborted = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        for (int s = 0; s < 2 * W && !aborted; s++) begin
          @(posedge clk); #2;
          if (reset) begin
            aborted = 1'b1;
            bus.sdr_readdata = '0;
            bus.sdr_readend  = 1'b0;
          end else begin
            wv = word_val(addr, s / 2);
            bus.sdr_readdata = '0;
            bus.sdr_readdata[16*s +: 16] = (s % 2 == 1) ? wv[31:16] : wv[15:0];
            bus.sdr_readend  = (s == 2 * W - 1);
          end
        end
        @(posedge clk); #2;
        bus.sdr_readdata = '0;
        bus.sdr_readend  = 1'b0;
      end
    end
  end

  // Monitor: burst protocol, output stability, scoreboard pops and done timing.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      outstanding = 1'b0;
      prev_stall  = 1'b0;
      prev_valid  = 1'b0;
    end else begin
      if (bus.sdr_readstart) begin
        check_eq("one_outstanding", outstanding, 1'b0);
        check_eq("readstart_gap", (cyc - last_end_cyc) >= 2, 1'b1);
        check_eq("burst_addr", bus.sdr_baseaddr, run_base + 32'(36 * rs_cnt));
        check_eq("nelems", bus.sdr_nelems, 30'd9);
        rs_cnt++;
        outstanding = 1'b1;
      end
      if (bus.sdr_readend) begin
        outstanding  = 1'b0;
        re_cnt++;
        last_end_cyc = cyc;
      end
      if (prev_stall) begin
        check_eq("stall_valid", bus.tri_valid, 1'b1);
        check_eq("stall_data", bus.tri_data, prev_data);
        check_eq("stall_index", bus.tri_index, prev_idx);
        check_eq("stall_last", bus.tri_last, prev_last);
      end
      if (bus.tri_valid && !prev_valid)
        check_eq("valid_latency", cyc - last_end_cyc, 1);
      if (bus.tri_valid && bus.tri_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("tri_data", bus.tri_data, e.data);
          check_eq("tri_index", bus.tri_index, e.idx);
          check_eq("tri_last", bus.tri_last, e.last);
        end
        acc_cnt++;
        acc_cyc.push_back(cyc);
        last_acc_cyc  = cyc;
        last_acc_data = bus.tri_data;
        last_acc_idx  = bus.tri_index;
        last_acc_last = bus.tri_last;
      end
      if (done) begin
        done_cnt++;
        check_eq("done_busy_low", busy, 1'b0);
        if (run_num == 0) check_eq("done_lat_empty", cyc - start_cyc, 1);
        else              check_eq("done_lat", cyc - last_acc_cyc, 1);
      end
      prev_stall = bus.tri_valid & ~bus.tri_ready;
      prev_valid = bus.tri_valid;
      prev_data  = bus.tri_data;
      prev_idx   = bus.tri_index;
      prev_last  = bus.tri_last;
    end
  end

  task automatic start_run(input logic [31:0] b, input int n);
    @(posedge clk); #1;
    run_base = b; run_num = n;
    rs_cnt = 0; re_cnt = 0; done_cnt = 0; acc_cnt = 0;
    acc_cyc.delete();
    start_cyc = cyc;
    start = 1'b1; base_addr = b; num_tris = IXW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("busy_after_start", busy, n != 0);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_eq("done_seen", done_cnt, 1);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; base_addr = 32'd0; num_tris = '0;
    bus.tri_ready = 1'b1;
    run_base = 32'd0; run_num = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", bus.tri_valid, 1'b0);
    check_eq("rst_baseaddr", bus.sdr_baseaddr, 32'd0);
    check_eq("rst_data", bus.tri_data, '0);

    // single triangle
    start_run(32'h1000, 1);
    wait_done(200);
    check_eq("t1_word0", last_acc_data[31:0], 32'h11);
    check_eq("t1_word8", last_acc_data[287:256], 32'h19);
    check_eq("t1_index", last_acc_idx, 16'd0);
    check_eq("t1_last", last_acc_last, 1'b1);
    check_eq("t1_bursts", rs_cnt, 1);

    // three triangles, consumer always ready
    start_run(32'h1000, 3);
    wait_done(300);
    check_eq("t2_bursts", rs_cnt, 3);
    check_eq("t2_accepts", acc_cnt, 3);

    // consumer stalls until the second burst has landed in capture
    bus.tri_ready = 1'b0;
    start_run(32'h1000, 3);
    k = 0;
    while (re_cnt < 2 && k < 200) begin @(negedge clk); k++; end
    check_eq("t3_second_end", re_cnt, 2);
    repeat (8) @(negedge clk);
    check_eq("t3_no_third_burst", rs_cnt, 2);
    check_eq("t3_held_index", bus.tri_index, 16'd0);
    @(posedge clk); #1 bus.tri_ready = 1'b1;
    wait_done(300);
    check_eq("t3_accepts", acc_cnt, 3);
    check_eq("t3_back_to_back", (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1, 1);
    check_eq("t3_bursts", rs_cnt, 3);

    // empty run
    start_run(32'h1000, 0);
    wait_done(20);
    check_eq("t4_no_burst", rs_cnt, 0);

    // upper halves nonzero, variable ready
    start_run(32'h2000, 4);
    k = 0;
    while (done_cnt == 0 && k < 600) begin
      @(posedge clk); #1 bus.tri_ready = 1'($urandom_range(0, 1));
      k++;
    end
    bus.tri_ready = 1'b1;
    wait_done(100);
    check_eq("t5_accepts", acc_cnt, 4);

    // start during WAIT ignored
    start_run(32'h3000, 2);
    k = 0;
    while (rs_cnt < 1 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1 start = 1'b1; base_addr = 32'h9000; num_tris = 16'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done(300);
    check_eq("t6_bursts", rs_cnt, 2);

    // reset mid-burst, then a clean run
    start_run(32'h4000, 2);
    k = 0;
    while (rs_cnt < 1 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_readstart", bus.sdr_readstart, 1'b0);
    check_eq("mid_rst_baseaddr", bus.sdr_baseaddr, 32'd0);
    check_eq("mid_rst_valid", bus.tri_valid, 1'b0);
    check_eq("mid_rst_data", bus.tri_data, '0);
    check_eq("mid_rst_index", bus.tri_index, 16'd0);
    check_eq("mid_rst_last", bus.tri_last, 1'b0);
    repeat (4) @(posedge clk);
    start_run(32'h5000, 2);
    wait_done(300);
    check_eq("t6_post_rst_accepts", acc_cnt, 2);
    check_eq("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
